uart_rx_line_buf: RTL and testbench
===================================

// Module: uart_rx_line_buf
// PURPOSE
//  8N1 UART receiver with byte FIFO. Consumes uart0_tx driven by the SoC on fpioa[0].
//  Deserialises each frame and buffers the bytes for a valid/ready reader.
//  Used as the sim/FPGA console sink; replaces CSR-printf scraping for UART output.
// PARAMETERS
//  BAUD_DIV    868  clk cycles per bit (100 MHz / 115200); legal range >= 4
//  FIFO_DEPTH  16   byte entries; power of two, >= 2
//  SYNC_STAGES 2    flops in the rxd input synchroniser
// PORTS
//  clk          in   1  single system clock
//  rst_n        in   1  asynchronous active-low reset
//  rxd_i        in   1  serial line; asynchronous; idles high
//  clr_i        in   1  synchronous flush: empties the FIFO and clears overflow_o
//  rdata_o      out  8  byte at the FIFO head
//  rvalid_o     out  1  FIFO not empty
//  rready_i     in   1  pop strobe; a pop happens when rvalid_o & rready_i
//  frame_err_o  out  1  one-cycle pulse when a stop bit is sampled low
//  overflow_o   out  1  sticky; set when a byte is dropped because the FIFO is full
//  fifo_cnt_o   out  $clog2(FIFO_DEPTH)+1  current occupancy
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, FIFO empty, synchroniser flops preset to 1.
//  - rxs is rxd_i after SYNC_STAGES flops. Edge detection is done on rxs only.
//  - Baud counter: down-counter; "tick" asserts when it reaches 0.
//  - FSM:
//    IDLE: on a falling edge of rxs, load the counter with BAUD_DIV/2-1 and go to START.
//    START: on tick, if rxs=0, load BAUD_DIV-1, clear bit_idx, go to DATA.
//      If rxs=1 the start was a glitch; go to IDLE with no error.
//    DATA: on tick, shift rxs into shreg[7] (LSB first), reload BAUD_DIV-1, bit_idx++.
//      After the 8th sample go to STOP.
//    STOP: on tick, if rxs=1, push shreg and go to IDLE.
//      If rxs=0, pulse frame_err_o, drop the byte, go to BREAK.
//    BREAK: wait until rxs=1, then go to IDLE. A held-low line yields exactly one error.
//  - Latency: a pushed byte appears on rdata_o/rvalid_o the cycle after the stop-sample cycle.
//  - FIFO is a first-word-fall-through register array. rdata_o holds while rvalid_o=1 and no pop.
//  - The full test uses the occupancy before any same-cycle pop:
//    full & push & pop -> push accepted, count unchanged, no overflow.
//    full & push & no pop -> byte dropped, overflow_o<=1.
//  - An empty FIFO ignores pops; rready_i while rvalid_o=0 has no effect.
//  - Pointers wrap modulo FIFO_DEPTH. Count is tracked separately to tell full from empty.
//  - clr_i: FIFO empty and overflow_o=0 next cycle. The FSM is not affected.
//    A push in the same cycle as clr_i is discarded.
//  - Reset mid-frame abandons the frame. After reset the FSM waits in IDLE for a fresh falling edge.
//  - Bit timing error: sampling at mid-bit tolerates about +/-4% baud mismatch. No resync within a frame.
// STRUCTURE
//  - Package uart_pkg:
//    typedef enum logic [2:0] {IDLE,START,DATA,STOP,BREAK} uart_rx_st_e;
//    localparams for frame data width (8) and stop bit count (1).
//  - Sub-module sync_fifo #(WIDTH=8, DEPTH=FIFO_DEPTH).
//    Ports: push, wdata, pop, rdata, empty, full, count, clr.
//    Overflow flag logic stays in the parent.
//  - The parent holds the synchroniser, baud counter, FSM, shift register and error flags.
// TESTING (bench uses BAUD_DIV=16, FIFO_DEPTH=4)
//  1. Send 0x55 then 0xA3 with ideal timing
//     -> rvalid_o rises 1 clk after each stop sample; pops return 0x55, then 0xA3; no errors.
//  2. Pull rxd_i low for 5 clks in idle
//     -> FSM returns to IDLE from START; no push, no frame_err_o; the next frame 0x7E decodes.
//  3. Send 0x41 with the stop bit held low for 40 clks
//     -> exactly one frame_err_o pulse; fifo_cnt_o stays 0; a following 0x42 is received correctly.
//  4. Send 5 bytes 0x01..0x05 with rready_i=0
//     -> fifo_cnt_o=4 and overflow_o=1; pops return 0x01..0x04.
//     Then assert clr_i -> overflow_o=0 and fifo_cnt_o=0.
//  5. FIFO full; the stop sample of 0x66 lands in the same cycle as a pop
//     -> byte accepted, count stays 4, overflow_o stays 0, 0x66 is last out.
//  6. Assert rst_n low during DATA bit 3 of 0x99, release, send 0x12
//     -> no partial byte pushed; 0x12 received; all outputs 0 during reset.

Source files
------------

// File: rtl/uart_rx_line_buf_pkg.sv
// uart_pkg: shared receiver state encoding and 8N1 frame geometry.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_st_e;
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
endpackage

// File: rtl/uart_rx_line_buf_fifo.sv
// sync_fifo: first-word-fall-through register FIFO with flush.
// A pop makes room for a same-cycle push even when full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;
    assign empty = cnt_q == '0;
    assign full  = cnt_q == CW'(DEPTH);
    assign rdata = empty ? '0 : mem_q[rp_q];
    assign count = cnt_q;
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        mem_d   = mem_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        if (do_push) begin
            mem_d[wp_q] = wdata;
            wp_d        = wp_q + 1'b1;
        end
        if (do_pop) rp_d = rp_q + 1'b1;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        // Flush wins over any same-cycle push or pop
        if (clr) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_rx_line_buf.sv
// uart_rx_line_buf: 8N1 UART receiver sampling mid-bit, feeding a byte FIFO
// for a valid/ready reader; reports framing errors and sticky overflow.
module uart_rx_line_buf
    import uart_pkg::*;
#(
    parameter int BAUD_DIV    = 868,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rxd_i,
    input  logic                          clr_i,
    output logic [7:0]                    rdata_o,
    output logic                          rvalid_o,
    input  logic                          rready_i,
    output logic                          frame_err_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam int BW = $clog2(DATA_BITS);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rxs, rxs_prev_q, fall, tick;
    uart_rx_st_e            state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   ferr_q, ferr_d, ovf_q, ovf_d;
    logic                   push, fifo_empty, fifo_full;
    assign rxs  = sync_q[SYNC_STAGES-1];
    assign fall = rxs_prev_q & ~rxs;
    assign tick = cnt_q == '0;
    always_comb begin
        sync_d  = (sync_q << 1) | SYNC_STAGES'(rxd_i);
        state_d = state_q;
        cnt_d   = tick ? cnt_q : cnt_q - 1'b1;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        ferr_d  = 1'b0;
        push    = 1'b0;
        case (state_q)
            IDLE: if (fall) begin
                cnt_d   = CW'(BAUD_DIV / 2 - 1);
                state_d = START;
            end
            START: if (tick) begin
                cnt_d   = CW'(BAUD_DIV - 1);
                bit_d   = '0;
                state_d = rxs ? IDLE : DATA;
            end
            DATA: if (tick) begin
                shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
                cnt_d   = CW'(BAUD_DIV - 1);
                bit_d   = bit_q + 1'b1;
                if (bit_q == BW'(DATA_BITS - 1)) state_d = STOP;
            end
            STOP: if (tick) begin
                push    = rxs;
                ferr_d  = ~rxs;
                state_d = rxs ? IDLE : BREAK;
            end
            BREAK: if (rxs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Full is judged before the same-cycle pop, so a pop rescues the byte
        ovf_d = clr_i ? 1'b0 : ovf_q | (push & fifo_full & ~rready_i);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '1;
            rxs_prev_q <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            ferr_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            rxs_prev_q <= rxs;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            ferr_q     <= ferr_d;
            ovf_q      <= ovf_d;
        end
    end
    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_i),
        .push  (push & ~clr_i),
        .wdata (shreg_q),
        .pop   (rready_i),
        .rdata (rdata_o),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_cnt_o)
    );
    assign rvalid_o    = ~fifo_empty;
    assign frame_err_o = ferr_q;
    assign overflow_o  = ovf_q;
endmodule

// File: tb/tb_uart_rx_line_buf.sv
// tb_uart_rx_line_buf: drives serial frames and checks the byte stream,
// error pulses and FIFO status against a queue-based reference.
module tb_uart_rx_line_buf;
    localparam int BAUD_DIV   = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int SYNC       = 2;
    // synchroniser + edge detect + half bit to mid start + nine bits to mid stop
    localparam int LAT = SYNC + 1 + BAUD_DIV / 2 + 9 * BAUD_DIV;

    logic       clk = 1'b0, rst_n = 1'b0, rxd = 1'b1, clr = 1'b0, rready = 1'b0;
    logic [7:0] rdata;
    logic       rvalid, ferr, ovf;
    logic [2:0] cnt;

    int checks = 0, failures = 0;
    int cyc = 0, err_cnt = 0, rise_cyc = -1;
    logic rv_prev = 1'b0;
    logic [7:0] mq[$];
    logic       movf = 1'b0;

    uart_rx_line_buf #(.BAUD_DIV(BAUD_DIV), .FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .rxd_i(rxd), .clr_i(clr), .rdata_o(rdata),
        .rvalid_o(rvalid), .rready_i(rready), .frame_err_o(ferr),
        .overflow_o(ovf), .fifo_cnt_o(cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (ferr) err_cnt++;
        if (rvalid && !rv_prev) rise_cyc = cyc;
        rv_prev = rvalid;
    end

    task automatic drive_bits(input logic v, input int n);
        rxd = v;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input logic [7:0] b, input int stop_low);
        drive_bits(1'b0, BAUD_DIV);
        for (int i = 0; i < 8; i++) drive_bits(b[i], BAUD_DIV);
        if (stop_low > 0) drive_bits(1'b0, stop_low);
        drive_bits(1'b1, BAUD_DIV);
    endtask

    task automatic model_rx(input logic [7:0] b);
        if (mq.size() < FIFO_DEPTH) mq.push_back(b);
        else movf = 1'b1;
    endtask

    task automatic pop_byte(output logic [7:0] d, output logic v);
        @(negedge clk);
        d = rdata; v = rvalid; rready = 1'b1;
        @(posedge clk); #1 rready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rdata, rvalid, ferr, ovf, cnt} !== 14'd0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0", {rdata, rvalid, ferr, ovf, cnt});
        end
        @(posedge clk); #1 rst_n = 1'b1;
        drive_bits(1'b1, 4);
        checks++;
        if (rvalid !== 1'b0 || cnt !== 3'd0) begin
            failures++; $display("FAIL post_reset_idle rvalid=%b cnt=%0d exp 0/0", rvalid, cnt);
        end
    endtask

    task automatic test_basic;
        logic [7:0] d; logic v; int start, e0;
        logic [7:0] bytes [2];
        bytes[0] = 8'h55; bytes[1] = 8'hA3;
        e0 = err_cnt;
        for (int k = 0; k < 2; k++) begin
            start = cyc;
            send_frame(bytes[k], 0);
            model_rx(bytes[k]);
            checks++;
            if (rise_cyc != start + LAT) begin
                failures++; $display("FAIL basic_latency byte=%h rise=%0d exp=%0d", bytes[k], rise_cyc - start, LAT);
            end
            pop_byte(d, v);
            checks++;
            if (!v || d !== mq[0]) begin
                failures++; $display("FAIL basic_data got=%h v=%b exp=%h", d, v, mq[0]);
            end
            void'(mq.pop_front());
        end
        checks++;
        if (err_cnt != e0 || rvalid !== 1'b0) begin
            failures++; $display("FAIL basic_clean errs=%0d rvalid=%b exp 0/0", err_cnt - e0, rvalid);
        end
    endtask

    task automatic test_glitch;
        logic [7:0] d; logic v; int e0;
        e0 = err_cnt;
        drive_bits(1'b0, 5);
        drive_bits(1'b1, 2 * BAUD_DIV);
        checks++;
        if (cnt !== 3'd0 || err_cnt != e0) begin
            failures++; $display("FAIL glitch_ignored cnt=%0d errs=%0d exp 0/0", cnt, err_cnt - e0);
        end
        send_frame(8'h7E, 0);
        model_rx(8'h7E);
        pop_byte(d, v);
        checks++;
        if (!v || d !== 8'h7E) begin
            failures++; $display("FAIL glitch_next got=%h v=%b exp=7e", d, v);
        end
        void'(mq.pop_front());
    endtask

    task automatic test_frame_err;
        logic [7:0] d; logic v; int e0;
        e0 = err_cnt;
        send_frame(8'h41, 40);
        drive_bits(1'b1, 2 * BAUD_DIV);
        checks++;
        if (err_cnt != e0 + 1) begin
            failures++; $display("FAIL ferr_pulses got=%0d exp=1", err_cnt - e0);
        end
        checks++;
        if (cnt !== 3'd0) begin
            failures++; $display("FAIL ferr_no_push cnt=%0d exp=0", cnt);
        end
        send_frame(8'h42, 0);
        model_rx(8'h42);
        pop_byte(d, v);
        checks++;
        if (!v || d !== 8'h42) begin
            failures++; $display("FAIL ferr_next got=%h v=%b exp=42", d, v);
        end
        void'(mq.pop_front());
    endtask

    task automatic test_overflow;
        logic [7:0] d; logic v;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 0);
            model_rx(8'(i));
        end
        checks++;
        if (cnt !== 3'(mq.size()) || ovf !== movf) begin
            failures++; $display("FAIL ovf_state cnt=%0d ovf=%b exp=%0d/%b", cnt, ovf, mq.size(), movf);
        end
        while (mq.size() > 0) begin
            pop_byte(d, v);
            checks++;
            if (!v || d !== mq[0]) begin
                failures++; $display("FAIL ovf_pop got=%h v=%b exp=%h", d, v, mq[0]);
            end
            void'(mq.pop_front());
        end
        send_frame(8'($urandom), 0);
        clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        movf = 1'b0;
        checks++;
        if (cnt !== 3'd0 || ovf !== 1'b0 || rvalid !== 1'b0) begin
            failures++; $display("FAIL clr cnt=%0d ovf=%b rvalid=%b exp 0/0/0", cnt, ovf, rvalid);
        end
    endtask

    task automatic test_full_pop_push;
        logic [7:0] d; logic [7:0] pd; logic v;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            d = 8'($urandom);
            send_frame(d, 0);
            model_rx(d);
        end
        fork
            send_frame(8'h66, 0);
            begin
                repeat (LAT - 1) @(posedge clk);
                @(negedge clk) pd = rdata; rready = 1'b1;
                @(posedge clk); #1 rready = 1'b0;
            end
        join
        checks++;
        if (pd !== mq[0]) begin
            failures++; $display("FAIL fullpop_data got=%h exp=%h", pd, mq[0]);
        end
        void'(mq.pop_front());
        mq.push_back(8'h66);
        checks++;
        if (cnt !== 3'd4 || ovf !== 1'b0) begin
            failures++; $display("FAIL fullpop_state cnt=%0d ovf=%b exp=4/0", cnt, ovf);
        end
        while (mq.size() > 0) begin
            pop_byte(d, v);
            checks++;
            if (!v || d !== mq[0]) begin
                failures++; $display("FAIL fullpop_drain got=%h v=%b exp=%h", d, v, mq[0]);
            end
            void'(mq.pop_front());
        end
        checks++;
        if (d !== 8'h66) begin
            failures++; $display("FAIL fullpop_last got=%h exp=66", d);
        end
    endtask

    task automatic test_random;
        logic [7:0] b, d; logic v;
        for (int i = 0; i < 8; i++) begin
            drive_bits(1'b1, $urandom_range(1, 20));
            b = 8'($urandom);
            send_frame(b, 0);
            model_rx(b);
            checks++;
            if (cnt !== 3'(mq.size())) begin
                failures++; $display("FAIL rand_cnt got=%0d exp=%0d", cnt, mq.size());
            end
            if ($urandom_range(0, 2) != 0 && mq.size() > 0) begin
                pop_byte(d, v);
                checks++;
                if (!v || d !== mq[0]) begin
                    failures++; $display("FAIL rand_pop got=%h v=%b exp=%h", d, v, mq[0]);
                end
                void'(mq.pop_front());
            end
        end
        checks++;
        if (ovf !== movf) begin
            failures++; $display("FAIL rand_ovf got=%b exp=%b", ovf, movf);
        end
        clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        mq.delete(); movf = 1'b0;
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] b, d; logic v; int e0;
        b = 8'h99;
        send_frame(8'($urandom), 0);
        drive_bits(1'b0, BAUD_DIV);
        for (int i = 0; i < 3; i++) drive_bits(b[i], BAUD_DIV);
        drive_bits(b[3], BAUD_DIV / 2);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rdata, rvalid, ferr, ovf, cnt} !== 14'd0) begin
            failures++; $display("FAIL midreset_outputs got=%h exp=0", {rdata, rvalid, ferr, ovf, cnt});
        end
        @(posedge clk); #1;
        drive_bits(b[3], BAUD_DIV / 2 - 1);
        for (int i = 4; i < 8; i++) drive_bits(b[i], BAUD_DIV);
        drive_bits(1'b1, 2 * BAUD_DIV);
        rst_n = 1'b1;
        mq.delete(); movf = 1'b0;
        e0 = err_cnt;
        drive_bits(1'b1, 4);
        checks++;
        if (cnt !== 3'd0 || rvalid !== 1'b0) begin
            failures++; $display("FAIL midreset_empty cnt=%0d rvalid=%b exp 0/0", cnt, rvalid);
        end
        send_frame(8'h12, 0);
        model_rx(8'h12);
        checks++;
        if (cnt !== 3'd1 || err_cnt != e0) begin
            failures++; $display("FAIL midreset_cnt cnt=%0d errs=%0d exp 1/0", cnt, err_cnt - e0);
        end
        pop_byte(d, v);
        checks++;
        if (!v || d !== 8'h12) begin
            failures++; $display("FAIL midreset_next got=%h v=%b exp=12", d, v);
        end
        void'(mq.pop_front());
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL timeout bench did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overflow();
        test_full_pop_push();
        test_random();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
